// File: rtl/polar_freq_estimator.sv
// Rebuilds full-turn phase from CORDIC vectoring output, differences consecutive phases,
// and emits the rounded window average of the phase step together with the window's peak magnitude.
module polar_freq_estimator #(
    parameter int unsigned AW      = 16,
    parameter int unsigned OW      = 16,
    parameter int unsigned LOG_AVG = 4,
    parameter int unsigned SQUELCH = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [OW-1:0] r_i,
    input  logic [AW-1:0] angle_i,
    input  logic [1:0]    quadrant_i,
    input  logic          clear_i,
    output logic [AW+1:0] freq_o,
    output logic [OW-1:0] peak_o,
    output logic          valid_o,
    output logic          squelch_o
);

    localparam int unsigned PW   = AW + 2;
    localparam int unsigned ACCW = PW + LOG_AVG;
    localparam int unsigned CW   = (LOG_AVG == 0) ? 1 : LOG_AVG;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG_AVG) - 1);

    typedef enum logic {EMPTY, RUN} state_t;

    state_t                   state, state_next;
    logic [PW-1:0]            phase, prev;
    logic signed [PW-1:0]     delta, freq_next;
    logic signed [ACCW-1:0]   acc, acc_sum, acc_rnd;
    logic [CW-1:0]            cnt;
    logic [OW-1:0]            peak, peak_max;
    logic                     below;
    logic                     load_prev, add, finish, flush, reject;

    assign phase    = {quadrant_i, angle_i};
    assign delta    = phase - prev;
    assign acc_sum  = acc + ACCW'(delta);
    assign peak_max = (r_i > peak) ? r_i : peak;

    // Round half up before the arithmetic shift; no rounding term for a single-sample window
    if (LOG_AVG == 0) begin : g_no_rnd
        assign acc_rnd = acc_sum;
    end else begin : g_rnd
        assign acc_rnd = acc_sum + ACCW'(1 << (LOG_AVG - 1));
    end

    assign freq_next = PW'(acc_rnd >>> LOG_AVG);

    // A zero threshold accepts everything
    if (SQUELCH == 0) begin : g_no_squelch
        assign below = 1'b0;
    end else begin : g_squelch
        assign below = (r_i < OW'(SQUELCH));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_prev  = 1'b0;
        add        = 1'b0;
        finish     = 1'b0;
        flush      = 1'b0;
        reject     = 1'b0;
        if (clear_i) begin
            state_next = EMPTY;
            flush      = 1'b1;
        end else if (valid_i) begin
            if (below) begin
                reject     = 1'b1;
                flush      = 1'b1;
                state_next = EMPTY;
            end else begin
                load_prev  = 1'b1;
                state_next = RUN;
                if (state == RUN) begin
                    if (cnt == CNT_LAST) begin
                        finish = 1'b1;
                    end else begin
                        add = 1'b1;
                    end
                end
            end
        end
    end

    // Window accumulator, previous phase and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev      <= '0;
            acc       <= '0;
            cnt       <= '0;
            peak      <= '0;
            freq_o    <= '0;
            peak_o    <= '0;
            valid_o   <= 1'b0;
            squelch_o <= 1'b0;
        end else begin
            valid_o   <= finish;
            squelch_o <= reject;
            if (flush) begin
                acc  <= '0;
                cnt  <= '0;
                peak <= '0;
            end else if (finish) begin
                acc    <= '0;
                cnt    <= '0;
                peak   <= '0;
                freq_o <= freq_next;
                peak_o <= peak_max;
            end else if (add) begin
                acc  <= acc_sum;
                cnt  <= cnt + CW'(1);
                peak <= peak_max;
            end
            if (load_prev) begin
                prev <= phase;
            end
        end
    end

endmodule

// File: tb/tb_polar_freq_estimator.sv
// Directed bench: three estimator instances (LOG_AVG 2/0/4) share stimulus and are
// checked every cycle against a queue-based phase-difference model plus literal expectations.
module tb_polar_freq_estimator;

    logic        clk;
    logic        rst_n;
    logic        vld;
    logic        clr;
    logic [1:0]  quad;
    logic [15:0] ang;
    logic [15:0] rr;

    logic [17:0] fw [3];
    logic [15:0] pw [3];
    logic        vw [3];
    logic        sw [3];

    localparam int LA [3] = '{2, 0, 4};
    localparam int SQ [3] = '{100, 100, 0};

    int n_cmp = 0;
    int n_bad = 0;

    polar_freq_estimator #(.AW(16), .OW(16), .LOG_AVG(2), .SQUELCH(100)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vld), .r_i(rr), .angle_i(ang),
        .quadrant_i(quad), .clear_i(clr), .freq_o(fw[0]), .peak_o(pw[0]),
        .valid_o(vw[0]), .squelch_o(sw[0]));

    polar_freq_estimator #(.AW(16), .OW(16), .LOG_AVG(0), .SQUELCH(100)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vld), .r_i(rr), .angle_i(ang),
        .quadrant_i(quad), .clear_i(clr), .freq_o(fw[1]), .peak_o(pw[1]),
        .valid_o(vw[1]), .squelch_o(sw[1]));

    polar_freq_estimator #(.AW(16), .OW(16), .LOG_AVG(4), .SQUELCH(0)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vld), .r_i(rr), .angle_i(ang),
        .quadrant_i(quad), .clear_i(clr), .freq_o(fw[2]), .peak_o(pw[2]),
        .valid_o(vw[2]), .squelch_o(sw[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: window of phase steps held in queues, averaged when full
    bit     have_prev [3];
    int     prev_m    [3];
    int     dq        [3][$];
    int     rq        [3][$];
    longint ef        [3];
    int     ep        [3];
    bit     ev        [3];
    bit     es        [3];
    int     m_p, m_d, m_mx;
    longint m_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                have_prev[i] = 1'b0;
                prev_m[i]    = 0;
                dq[i].delete();
                rq[i].delete();
                ef[i] = 0;
                ep[i] = 0;
                ev[i] = 1'b0;
                es[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                ev[i] = 1'b0;
                es[i] = 1'b0;
                if (clr) begin
                    have_prev[i] = 1'b0;
                    dq[i].delete();
                    rq[i].delete();
                end else if (vld) begin
                    m_p = int'(quad) * 65536 + int'(ang);
                    if (int'(rr) < SQ[i]) begin
                        es[i]        = 1'b1;
                        have_prev[i] = 1'b0;
                        dq[i].delete();
                        rq[i].delete();
                    end else if (!have_prev[i]) begin
                        prev_m[i]    = m_p;
                        have_prev[i] = 1'b1;
                    end else begin
                        m_d = m_p - prev_m[i];
                        if (m_d >= 131072) m_d -= 262144;
                        else if (m_d < -131072) m_d += 262144;
                        dq[i].push_back(m_d);
                        rq[i].push_back(int'(rr));
                        prev_m[i] = m_p;
                        if (dq[i].size() == (1 << LA[i])) begin
                            m_sum = 0;
                            m_mx  = 0;
                            foreach (dq[i][k]) m_sum += longint'(dq[i][k]);
                            foreach (rq[i][k]) if (rq[i][k] > m_mx) m_mx = rq[i][k];
                            if (LA[i] > 0) m_sum += longint'(1 << (LA[i] - 1));
                            ef[i] = m_sum >>> LA[i];
                            ep[i] = m_mx;
                            ev[i] = 1'b1;
                            dq[i].delete();
                            rq[i].delete();
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("freq[%0d]", i), longint'($signed(fw[i])), ef[i]);
            chk($sformatf("peak[%0d]", i), longint'(pw[i]), longint'(ep[i]));
            chk($sformatf("valid[%0d]", i), longint'(vw[i]), longint'(ev[i]));
            chk($sformatf("squelch[%0d]", i), longint'(sw[i]), longint'(es[i]));
        end
    end

    task automatic smp(input int q, input int a, input int r);
        quad = 2'(q);
        ang  = 16'(a);
        rr   = 16'(r);
        vld  = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Constant rotation of +1000 per sample; the primer carries the largest magnitude
    task automatic rotation();
        int r;
        for (int k = 0; k <= 16; k++) begin
            r = (k == 0) ? 900 : 200 + (k * 53) % 200;
            smp(0, k * 1000, r);
            if (k == 3) chk("rot_early_valid", longint'(vw[0]), 0);
            if (k == 4) begin
                chk("rot_valid", longint'(vw[0]), 1);
                chk("rot_freq", longint'($signed(fw[0])), 1000);
                chk("rot_peak", longint'(pw[0]), 359);
            end
            if (k == 16) begin
                chk("rot16_valid", longint'(vw[2]), 1);
                chk("rot16_freq", longint'($signed(fw[2])), 1000);
                chk("rot16_peak", longint'(pw[2]), 395);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        vld   = 1'b0;
        clr   = 1'b0;
        quad  = '0;
        ang   = '0;
        rr    = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_freq", longint'(fw[i]), 0);
            chk("rst_valid", longint'(vw[i]), 0);
        end
        rst_n = 1'b1;
        idle(1);

        do_clear();
        rotation();

        do_clear();
        smp(3, 65000, 500);
        smp(0, 500, 500);
        chk("wrap_pos_valid", longint'(vw[1]), 1);
        chk("wrap_pos_freq", longint'($signed(fw[1])), 1036);
        smp(3, 65000, 400);
        chk("wrap_neg_freq", longint'($signed(fw[1])), -1036);
        chk("wrap_neg_peak", longint'(pw[1]), 400);

        do_clear();
        smp(0, 10, 200);
        smp(0, 11, 200);
        smp(0, 12, 200);
        smp(0, 13, 200);
        smp(0, 15, 200);
        chk("round_pos", longint'($signed(fw[0])), 1);
        smp(0, 14, 200);
        smp(0, 13, 200);
        smp(0, 12, 200);
        smp(0, 10, 200);
        chk("round_neg", longint'($signed(fw[0])), -1);
        smp(0, 12, 200);
        idle(2);
        smp(0, 14, 200);
        idle(1);
        smp(0, 16, 200);
        smp(0, 18, 200);
        chk("round_gap_valid", longint'(vw[0]), 1);
        chk("round_gap", longint'($signed(fw[0])), 2);

        do_clear();
        smp(0, 0, 200);
        smp(0, 100, 200);
        smp(0, 200, 50);
        chk("sq_pulse", longint'(sw[0]), 1);
        chk("sq_no_valid", longint'(vw[0]), 0);
        smp(0, 300, 40);
        chk("sq_b2b", longint'(sw[0]), 1);
        for (int k = 0; k < 5; k++) begin
            smp(0, 400 + k * 100, 300);
            if (k == 3) chk("sq_early_valid", longint'(vw[0]), 0);
        end
        chk("sq_after_valid", longint'(vw[0]), 1);
        chk("sq_after_freq", longint'($signed(fw[0])), 100);

        do_clear();
        smp(0, 0, 200);
        smp(0, 100, 200);
        smp(0, 200, 200);
        clr  = 1'b1;
        vld  = 1'b1;
        ang  = 16'd5000;
        rr   = 16'd10;
        @(posedge clk);
        #1;
        clr = 1'b0;
        vld = 1'b0;
        chk("clr_no_squelch", longint'(sw[0]), 0);
        for (int k = 0; k < 5; k++) begin
            smp(0, 300 + k * 70, 250);
            if (k == 3) chk("clr_early_valid", longint'(vw[0]), 0);
        end
        chk("clr_valid", longint'(vw[0]), 1);
        chk("clr_freq", longint'($signed(fw[0])), 70);

        do_clear();
        smp(0, 0, 200);
        smp(0, 1000, 200);
        smp(0, 2000, 200);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("arst_freq", longint'(fw[i]), 0);
            chk("arst_peak", longint'(pw[i]), 0);
            chk("arst_valid", longint'(vw[i]), 0);
            chk("arst_squelch", longint'(sw[i]), 0);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        rotation();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/polar_freq_estimator.md
# polar_freq_estimator

Downstream consumer of the CORDIC vectoring stage. It takes each magnitude / in-quadrant angle / quadrant triple, rebuilds a full-turn phase, and differences consecutive phases to get instantaneous frequency. It averages 2^LOG_AVG differences per output word and tracks the window's peak magnitude. A squelch rejects low-magnitude samples, whose phase is meaningless.

## Interface
- AW, 16: angle width of the upstream stage; full-turn phase is AW+2 bits.
- OW, 16: magnitude width.
- LOG_AVG, 4: log2 of the number of phase differences averaged per output (0 is legal).
- SQUELCH, 0: unsigned OW-bit magnitude threshold; a sample is accepted iff r_i >= SQUELCH.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  sample strobe; no backpressure.
- r_i  in  OW  unsigned magnitude.
- angle_i  in  AW  unsigned angle inside the quadrant.
- quadrant_i  in  2  quadrant index, 0..3, counter-clockwise.
- clear_i  in  1  synchronous flush.
- freq_o  out  AW+2  signed averaged phase step, in units of 2^-(AW+2) turn per sample.
- peak_o  out  OW  maximum r_i over the window's accepted differencing samples.
- valid_o  out  1  one-cycle strobe qualifying freq_o and peak_o.
- squelch_o  out  1  one-cycle pulse: a valid sample was rejected.

## Operation
- Phase: p = {quadrant_i, angle_i}, unsigned, AW+2 bits, modulo 2^(AW+2).
- State EMPTY (no previous phase held) or RUN.
- EMPTY, accepted valid sample: prev <= p; go to RUN; acc, cnt and peak stay 0; no delta.
- RUN, accepted valid sample:
  - d = p - prev, computed in AW+2 bits and read as signed (natural wrap; range -2^(AW+1)..2^(AW+1)-1).
  - prev <= p; acc += d; peak <= max(peak, r_i); cnt++.
- Window completion: when cnt == 2^LOG_AVG-1 and a delta is accepted:
  - freq_o <= (acc + d + 2^(LOG_AVG-1)) >>> LOG_AVG. The add is omitted when LOG_AVG = 0.
  - peak_o <= max(peak, r_i); valid_o <= 1.
  - acc, cnt and peak clear; state stays RUN.
- acc width is AW+2+LOG_AVG signed, so it never overflows. The rounded average always fits AW+2 bits; no saturation logic.
- Rejected valid sample (r_i < SQUELCH), any state:
  - squelch_o <= 1; go to EMPTY.
  - acc, cnt and peak clear; the partial window is discarded; no valid_o.
- clear_i: go to EMPTY, clear acc, cnt and peak. It overrides valid_i in the same cycle (that sample is ignored, no squelch_o). valid_o and squelch_o are 0 next cycle.
- valid_i low: hold everything; valid_o and squelch_o are 0.

## Timing
- Reset values: freq_o=0, peak_o=0, valid_o=0, squelch_o=0, state EMPTY, acc/cnt/peak/prev=0.
- Reset mid-window discards all history; the first sample after release primes prev.
- Latency: valid_o asserts exactly 1 cycle after the valid_i cycle carrying the window's last sample.
- freq_o and peak_o hold their values until the next valid_o.
- Throughput: valid_i may be high every cycle.
  - First output needs 1 + 2^LOG_AVG accepted samples.
  - Later outputs come every 2^LOG_AVG accepted samples.
- Gaps in valid_i do not reset the window.
- squelch_o asserts 1 cycle after the rejected sample.
- Back-to-back rejected samples give back-to-back squelch_o pulses.

## Test plan
- Constant rotation (AW=16, LOG_AVG=2, SQUELCH=0): quadrant 0, angle_i = 0, 1000, 2000, ... on consecutive cycles.
  - valid_o at the cycle after the 5th sample with freq_o=1000.
  - Repeated every 4 samples; peak_o = max r_i.
- Wrap-around: prev {3, 65000}, next {0, 500} -> d = +1036. Reverse order -> d = -1036. Check freq_o with LOG_AVG=0.
- Rounding (LOG_AVG=2):
  - deltas 1, 1, 1, 2 -> freq_o = 1.
  - deltas -1, -1, -1, -2 -> freq_o = -1.
  - deltas 2, 2, 2, 2 with gaps in valid_i -> freq_o = 2.
- Squelch (SQUELCH=100, LOG_AVG=2): 3rd sample has r_i=50.
  - squelch_o pulses; no valid_o for that window.
  - Next valid_o comes after 1+4 further accepted samples.
- clear_i asserted together with valid_i mid-window:
  - the sample is ignored, no squelch_o;
  - the next sample primes;
  - the output appears after 1+2^LOG_AVG more samples.
- Async reset asserted mid-window (including between clock edges):
  - all outputs read 0 immediately;
  - after release, behaviour matches the constant-rotation case from scratch.
